// File: rtl/moore_seq_detector_pkg.sv
// Shared constants and elaboration-time helpers for the Moore serial pattern detector.
// The hit counter itself is gated by MOORE_SEQ_HITCNT_EN; nothing here depends on it.
package moore_seq_pkg;

  localparam bit MODE_NONOVERLAP = 1'b0;
  localparam bit MODE_OVERLAP    = 1'b1;

  // Patterns are passed to the helpers right-aligned in a fixed-width container.
  localparam int SEQ_MAX_PAT_W = 64;

  typedef logic [SEQ_MAX_PAT_W-1:0] seq_pattern_t;

  function automatic int SEQ_STATE_W(input int pat_w);
    return (pat_w < 1) ? 1 : $clog2(pat_w + 1);
  endfunction

  // Longest prefix of the pattern that is a suffix of (first k pattern bits, inBit);
  // pattern[pat_w-1] is the first bit of the sequence on the wire.
  function automatic int seq_next(input int state, input logic inBit,
                                  input seq_pattern_t pattern, input int pat_w,
                                  input bit overlap);
    int   k;
    int   best;
    int   pos;
    bit   ok;
    logic seqBit;
    k    = (state == pat_w && overlap == MODE_NONOVERLAP) ? 0 : state;
    best = 0;
    for (int j = 1; j <= pat_w; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++) begin
          pos    = k + 1 - j + i;
          seqBit = (pos == k) ? inBit : pattern[pat_w-1-pos];
          if (pattern[pat_w-1-i] != seqBit) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/moore_seq_detector_if.sv
// Stream-side bundle of the pattern detector: source drives clear/valid/data, detector returns status.
// The hit_count wire exists only when MOORE_SEQ_HITCNT_EN is defined.
interface moore_seq_detector_if
  import moore_seq_pkg::*;
#(
  parameter int PAT_W = 4
`ifdef MOORE_SEQ_HITCNT_EN
  , parameter int CNT_W = 8
`endif
) ();

  logic                          clear;
  logic                          in_valid;
  logic                          in;
  logic                          match;
  logic [SEQ_STATE_W(PAT_W)-1:0] state_o;
`ifdef MOORE_SEQ_HITCNT_EN
  logic [CNT_W-1:0]              hit_count;
`endif

  modport master (
    output clear,
    output in_valid,
    output in,
    input  match,
    input  state_o
`ifdef MOORE_SEQ_HITCNT_EN
    , input hit_count
`endif
  );

  modport slave (
    input  clear,
    input  in_valid,
    input  in,
    output match,
    output state_o
`ifdef MOORE_SEQ_HITCNT_EN
    , output hit_count
`endif
  );

endinterface

// File: rtl/moore_seq_detector_hit_counter.sv
// Saturating match counter with synchronous clear and asynchronous reset.
// Only compiled and instantiated when MOORE_SEQ_HITCNT_EN is defined.
`ifdef MOORE_SEQ_HITCNT_EN
module moore_seq_hit_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Hold at all-ones rather than wrapping, so a full counter still means "at least this many".
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && count_q != {CNT_W{1'b1}}) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`endif

// File: rtl/moore_seq_detector.sv
// Moore detector for an arbitrary PAT_W-bit serial pattern, overlapping or restarting after a match.
// Optional saturating hit counter is enabled with MOORE_SEQ_HITCNT_EN.
module moore_seq_detector
  import moore_seq_pkg::*;
#(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = MODE_OVERLAP
`ifdef MOORE_SEQ_HITCNT_EN
  , parameter int           CNT_W   = 8
`endif
) (
  input  logic               clk,
  input  logic               areset,
  moore_seq_detector_if.slave bus
);

  localparam int            SW        = SEQ_STATE_W(PAT_W);
  localparam int            NUM_CODES = 2 ** SW;
  localparam logic [SW-1:0] ST_IDLE   = '0;
  localparam logic [SW-1:0] ST_MATCH  = SW'(PAT_W);

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic          match_q;
  logic          match_d;
  logic [SW-1:0] step_state;

  // Transition table is fixed at elaboration; unreachable encodings fall back to idle.
  logic [SW-1:0] next_lut [NUM_CODES][2];

  for (genvar k = 0; k < NUM_CODES; k++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      if (k <= PAT_W) begin : g_live
        assign next_lut[k][b] =
          SW'(seq_next(k, 1'(b), SEQ_MAX_PAT_W'(PATTERN), PAT_W, OVERLAP));
      end else begin : g_dead
        assign next_lut[k][b] = ST_IDLE;
      end
    end
  end

  assign step_state = next_lut[state_q][bus.in];

  // Clear beats an accepted bit; without a valid bit everything simply holds.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    if (bus.clear) begin
      state_d = ST_IDLE;
      match_d = 1'b0;
    end else if (bus.in_valid) begin
      state_d = step_state;
      match_d = (step_state == ST_MATCH);
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  assign bus.match   = match_q;
  assign bus.state_o = state_q;

`ifdef MOORE_SEQ_HITCNT_EN
  logic hit_inc;

  assign hit_inc = !bus.clear && bus.in_valid && (step_state == ST_MATCH);

  moore_seq_hit_counter #(
    .CNT_W (CNT_W)
  ) u_hit_counter (
    .clk     (clk),
    .areset  (areset),
    .clear_i (bus.clear),
    .inc_i   (hit_inc),
    .count_o (bus.hit_count)
  );
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed bench for moore_seq_detector: overlapping, non-overlapping and narrow-counter instances share one stream.
// Hit-count checks are active only when MOORE_SEQ_HITCNT_EN is defined.
module tb_moore_seq_detector;
  import moore_seq_pkg::*;

  logic clk = 1'b0;
  logic areset;

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // Overlap/non-overlap stream 1,0,1,1,0,1,1 with hand-computed expectations
  int ovBits  [7] = '{1, 0, 1, 1, 0, 1, 1};
  int ovState [7] = '{1, 2, 3, 4, 2, 3, 4};
  int noState [7] = '{1, 2, 3, 4, 0, 1, 1};
  int ovHits  [7] = '{0, 0, 0, 1, 1, 1, 2};
  int noHits  [7] = '{0, 0, 0, 1, 1, 1, 1};

  // Valid-gap stream: gap cycles carry garbage data
  int gapValid [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
  int gapBits  [8] = '{1, 0, 0, 1, 1, 0, 1, 0};
  int gapState [8] = '{1, 1, 2, 2, 3, 3, 4, 4};
  int gapHits  [8] = '{0, 0, 0, 0, 0, 0, 1, 1};

  // Partial prefix fallback 101 -> 1010 lands in state 2
  int fbBits  [6] = '{1, 0, 1, 0, 1, 1};
  int fbState [6] = '{1, 2, 3, 2, 3, 4};

  logic [3:0] pat = 4'b1011;

`ifdef MOORE_SEQ_HITCNT_EN
  moore_seq_detector_if #(.PAT_W(4), .CNT_W(8)) ifOv ();
  moore_seq_detector_if #(.PAT_W(4), .CNT_W(8)) ifNo ();
  moore_seq_detector_if #(.PAT_W(4), .CNT_W(2)) ifSat ();
`else
  moore_seq_detector_if #(.PAT_W(4)) ifOv ();
  moore_seq_detector_if #(.PAT_W(4)) ifNo ();
  moore_seq_detector_if #(.PAT_W(4)) ifSat ();
`endif

  moore_seq_detector #(
    .PAT_W(4), .PATTERN(4'b1011), .OVERLAP(MODE_OVERLAP)
`ifdef MOORE_SEQ_HITCNT_EN
    , .CNT_W(8)
`endif
  ) uOv (.clk(clk), .areset(areset), .bus(ifOv));

  moore_seq_detector #(
    .PAT_W(4), .PATTERN(4'b1011), .OVERLAP(MODE_NONOVERLAP)
`ifdef MOORE_SEQ_HITCNT_EN
    , .CNT_W(8)
`endif
  ) uNo (.clk(clk), .areset(areset), .bus(ifNo));

  moore_seq_detector #(
    .PAT_W(4), .PATTERN(4'b1011), .OVERLAP(MODE_OVERLAP)
`ifdef MOORE_SEQ_HITCNT_EN
    , .CNT_W(2)
`endif
  ) uSat (.clk(clk), .areset(areset), .bus(ifSat));

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic driveInputs(input logic clr, input logic vld, input logic b);
    ifOv.clear  = clr; ifOv.in_valid  = vld; ifOv.in  = b;
    ifNo.clear  = clr; ifNo.in_valid  = vld; ifNo.in  = b;
    ifSat.clear = clr; ifSat.in_valid = vld; ifSat.in = b;
  endtask

  // Drive one cycle and return 1 time unit after the rising edge
  task automatic applyStimulus(input logic clr, input logic vld, input logic b);
    driveInputs(clr, vld, b);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int sOv, input int sNo, input int sSat,
                             input int hOv, input int hNo, input int hSat);
    checkValue({tag, " ov.state"},  32'(ifOv.state_o),  32'(sOv));
    checkValue({tag, " no.state"},  32'(ifNo.state_o),  32'(sNo));
    checkValue({tag, " sat.state"}, 32'(ifSat.state_o), 32'(sSat));
    checkValue({tag, " ov.match"},  32'(ifOv.match),  (sOv  == 4) ? 32'd1 : 32'd0);
    checkValue({tag, " no.match"},  32'(ifNo.match),  (sNo  == 4) ? 32'd1 : 32'd0);
    checkValue({tag, " sat.match"}, 32'(ifSat.match), (sSat == 4) ? 32'd1 : 32'd0);
`ifdef MOORE_SEQ_HITCNT_EN
    checkValue({tag, " ov.hits"},  32'(ifOv.hit_count),  32'(hOv));
    checkValue({tag, " no.hits"},  32'(ifNo.hit_count),  32'(hNo));
    checkValue({tag, " sat.hits"}, 32'(ifSat.hit_count), 32'(hSat));
`else
    if (hOv < 0 || hNo < 0 || hSat < 0) $display("[TB] negative hit expectation in %s", tag);
`endif
  endtask

  initial begin
    int hv;
    int hs;
    areset = 1'b1;
    driveInputs(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reset", 0, 0, 0, 0, 0, 0);
    areset = 1'b0;

    // Partial match, then asynchronous reset between edges
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("partial1", 1, 1, 1, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("partial3", 3, 3, 3, 0, 0, 0);
    driveInputs(1'b0, 1'b0, 1'b0);
    #2;
    areset = 1'b1;
    #1;
    checkOutput("asyncReset", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'(i));
      checkOutput($sformatf("holdAfterReset%0d", i), 0, 0, 0, 0, 0, 0);
    end

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, 1'(ovBits[i]));
      checkOutput($sformatf("overlap%0d", i), ovState[i], noState[i], ovState[i],
                  ovHits[i], noHits[i], ovHits[i]);
    end

    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("clearIdle", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'(gapValid[i]), 1'(gapBits[i]));
      checkOutput($sformatf("gap%0d", i), gapState[i], gapState[i], gapState[i],
                  gapHits[i], gapHits[i], gapHits[i]);
    end

    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("clearAfterGap", 0, 0, 0, 0, 0, 0);

    // Clear coincident with the final pattern bit discards it
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("prePriority", 3, 3, 3, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("clearPriority", 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("afterPriority", 0, 0, 0, 0, 0, 0);

    // Five back-to-back matches; the 2-bit counter must stick at 3
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, pat[3 - (i % 4)]);
      hv = (i + 1) / 4;
      hs = (hv > 3) ? 3 : hv;
      checkOutput($sformatf("saturate%0d", i), (i % 4) + 1, (i % 4) + 1, (i % 4) + 1,
                  hv, hv, hs);
    end

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 1'(fbBits[i]));
      hv = (i == 5) ? 6 : 5;
      checkOutput($sformatf("fallback%0d", i), fbState[i], fbState[i], fbState[i],
                  hv, hv, 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
